// File: rtl/sdram_responder.sv
// sdram_responder: fixed-latency on-chip stand-in for the SDRAM behind memory_control.
// Requests are rising edges of the read/write strobes. Addresses are bit offsets and
// are divided down to word indices. Sticky flags record dropped, misaligned and
// out-of-range requests.
module sdram_responder #(
  parameter int W      = 16,
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 3,
  parameter int WR_CYC = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        readaddress,
  output logic [W-1:0]             readdata,
  output logic                     rd_valid,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        writeaddress,
  input  logic [W-1:0]             writedata,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [W-1:0]             init_data,
  output logic                     busy,
  output logic                     err_drop,
  output logic                     err_align,
  output logic                     err_range
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(W);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          read_q, write_q;
  logic          rd_req, wr_req;
  logic [W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] rd_idx_full, wr_idx_full;
  logic              rd_in_range, wr_in_range, rd_aligned, wr_aligned;
  logic [AW-1:0]     rd_word, rd_word_n;
  logic              rd_oor, rd_oor_n;
  logic              acc_rd, acc_wr, drop, rd_done;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [W-1:0]      mem_wdata;

  assign rd_req      = read & ~read_q;
  assign wr_req      = write & ~write_q;
  assign rd_idx_full = readaddress / W_A;
  assign wr_idx_full = writeaddress / W_A;
  assign rd_in_range = rd_idx_full < DEPTH_A;
  assign wr_in_range = wr_idx_full < DEPTH_A;
  assign rd_aligned  = (readaddress % W_A) == '0;
  assign wr_aligned  = (writeaddress % W_A) == '0;
  assign busy        = state != IDLE;

  // Next-state logic: accept requests in IDLE (write has priority), count down the
  // latency in RD/WR, and pick the single memory write source for this edge.
  // A read loads RD_LAT so that readdata lands exactly RD_LAT edges after acceptance.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    drop      = 1'b0;
    rd_done   = 1'b0;
    rd_word_n = rd_word;
    rd_oor_n  = rd_oor;
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = init_data;
    case (state)
      IDLE: begin
        if (wr_req) begin
          acc_wr    = 1'b1;
          drop      = rd_req;
          mem_we    = wr_in_range;
          mem_waddr = wr_idx_full[AW-1:0];
          mem_wdata = writedata;
          if (WR_CYC > 1) begin
            state_n = WR;
            cnt_n   = CW'(WR_CYC - 1);
          end
        end else if (rd_req) begin
          acc_rd    = 1'b1;
          state_n   = RD;
          cnt_n     = CW'(RD_LAT);
          rd_word_n = rd_idx_full[AW-1:0];
          rd_oor_n  = ~rd_in_range;
        end else if (init_we) begin
          mem_we = 1'b1;
        end
      end
      RD: begin
        drop  = rd_req | wr_req;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      WR: begin
        drop  = rd_req | wr_req;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, strobe history, read result and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      readdata  <= '0;
      rd_valid  <= 1'b0;
      rd_word   <= '0;
      rd_oor    <= 1'b0;
      err_drop  <= 1'b0;
      err_align <= 1'b0;
      err_range <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      read_q    <= read;
      write_q   <= write;
      rd_word   <= rd_word_n;
      rd_oor    <= rd_oor_n;
      rd_valid  <= rd_done;
      if (rd_done) begin
        readdata <= rd_oor ? '0 : mem[rd_word];
      end
      err_drop  <= err_drop | drop;
      err_align <= err_align | (acc_wr & ~wr_aligned) | (acc_rd & ~rd_aligned);
      err_range <= err_range | (acc_wr & ~wr_in_range) | (acc_rd & ~rd_in_range);
    end
  end

  // Word storage; contents survive reset, nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed request sequences, an edge-numbered reference
// model compared every cycle, and literal checks on the headline scenarios.
module tb_sdram_responder;

  localparam int W      = 16;
  localparam int ADDR_W = 25;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;
  localparam int WR_CYC = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              read, write, init_we;
  logic [ADDR_W-1:0] readaddress, writeaddress;
  logic [W-1:0]      writedata, init_data, readdata;
  logic [9:0]        init_addr;
  logic              rd_valid, busy, err_drop, err_align, err_range;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  sdram_responder #(
    .W(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .read(read), .readaddress(readaddress), .readdata(readdata), .rd_valid(rd_valid),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .busy(busy), .err_drop(err_drop), .err_align(err_align), .err_range(err_range)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request reserves the responder up to a known edge
  // number; reads deliver the word seen at acceptance RD_LAT edges later.
  int         e_cnt = 0;
  int         free_edge = 0;
  bit         m_live = 0;
  bit         p_read, p_write;
  bit         rd_pend;
  int         rd_due;
  logic [15:0] rd_val;
  bit         rd_val_known;
  logic [15:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic [15:0] x_readdata;
  bit         x_rd_known, x_valid, x_busy, x_drop, x_align, x_range;

  always @(posedge clk) begin
    bit rr, ww;
    int idx;
    e_cnt++;
    if (rst) begin
      m_live     = 1;
      free_edge  = e_cnt + 1;
      rd_pend    = 0;
      x_readdata = '0;
      x_rd_known = 1;
      x_valid    = 0;
      x_drop     = 0;
      x_align    = 0;
      x_range    = 0;
      p_read     = 0;
      p_write    = 0;
    end else if (m_live) begin
      rr = read && !p_read;
      ww = write && !p_write;
      p_read  = read;
      p_write = write;
      x_valid = 0;
      if (rd_pend && e_cnt == rd_due) begin
        x_readdata = rd_val;
        x_rd_known = rd_val_known;
        x_valid    = 1;
        rd_pend    = 0;
      end
      if (e_cnt >= free_edge) begin
        if (ww) begin
          idx = int'(writeaddress) / W;
          if (int'(writeaddress) % W != 0) x_align = 1;
          if (idx < DEPTH) begin
            m_mem[idx]   = writedata;
            m_known[idx] = 1;
          end else begin
            x_range = 1;
          end
          free_edge = e_cnt + WR_CYC;
          if (rr) x_drop = 1;
        end else if (rr) begin
          idx = int'(readaddress) / W;
          if (int'(readaddress) % W != 0) x_align = 1;
          if (idx < DEPTH) begin
            rd_val       = m_mem[idx];
            rd_val_known = m_known[idx];
          end else begin
            rd_val       = '0;
            rd_val_known = 1;
            x_range      = 1;
          end
          rd_pend   = 1;
          rd_due    = e_cnt + RD_LAT;
          free_edge = e_cnt + RD_LAT + 1;
        end else if (init_we) begin
          m_mem[init_addr]   = init_data;
          m_known[init_addr] = 1;
        end
      end else if (rr || ww) begin
        x_drop = 1;
      end
    end
    x_busy = (e_cnt + 1 < free_edge);
    #1;
    if (m_live) begin
      if (x_rd_known) checkOutput("model_readdata", 32'(readdata), 32'(x_readdata));
      checkOutput("model_rd_valid", 32'(rd_valid), 32'(x_valid));
      checkOutput("model_busy", 32'(busy), 32'(x_busy));
      checkOutput("model_err_drop", 32'(err_drop), 32'(x_drop));
      checkOutput("model_err_align", 32'(err_align), 32'(x_align));
      checkOutput("model_err_range", 32'(err_range), 32'(x_range));
    end
  end

  // Drive one edge's worth of request inputs from a negedge, return at the next negedge.
  task automatic applyStimulus(input logic rd, input logic [ADDR_W-1:0] ra,
                               input logic wr, input logic [ADDR_W-1:0] wa,
                               input logic [W-1:0] wd);
    read         = rd;
    readaddress  = ra;
    write        = wr;
    writeaddress = wa;
    writedata    = wd;
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] a, input logic [W-1:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Edges elapsed from the current negedge until rd_valid is seen, bounded.
  task automatic waitValid(input string name, output int lat);
    lat = 0;
    while (!rd_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!rd_valid) begin
      assert_cnt++;
      fail_cnt++;
      $display("[TB] FAIL %s_timeout: got no rd_valid expected pulse within 12 edges", name);
    end
  endtask

  task automatic countValid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rd_valid) pulses++;
    end
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    int lat;
    int n;
    rst = 1'b1;
    read = 0; write = 0; init_we = 0;
    readaddress = '0; writeaddress = '0; writedata = '0;
    init_addr = '0; init_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_readdata", 32'(readdata), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("reset_errs", {29'd0, err_drop, err_align, err_range}, 32'h0);
    rst = 1'b0;

    // Preloaded word 5 read back at bit address 80.
    preload(10'd5, 16'h00AA);
    applyStimulus(1, 25'd80, 0, 25'd0, 16'h0);
    checkOutput("t1_busy_after_accept", 32'(busy), 32'h1);
    waitValid("t1", lat);
    checkOutput("t1_latency", lat, 3);
    checkOutput("t1_readdata", 32'(readdata), 32'h00AA);
    checkOutput("t1_busy_done", 32'(busy), 32'h0);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    // Write then read at the earliest legal edge (acceptance + 9).
    applyStimulus(0, 25'd0, 1, 25'd160, 16'h1234);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    repeat (7) @(negedge clk);
    applyStimulus(1, 25'd160, 0, 25'd0, 16'h0);
    checkOutput("t2_read_accepted", 32'(busy), 32'h1);
    waitValid("t2", lat);
    checkOutput("t2_latency", lat, 3);
    checkOutput("t2_readdata", 32'(readdata), 32'h1234);
    checkOutput("t2_err_drop", 32'(err_drop), 32'h0);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    // Read two edges into a write is dropped; a later read works.
    applyStimulus(0, 25'd0, 1, 25'd320, 16'h5555);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    applyStimulus(1, 25'd160, 0, 25'd0, 16'h0);
    checkOutput("t3_err_drop", 32'(err_drop), 32'h1);
    countValid(10, n);
    checkOutput("t3_no_rd_valid", n, 0);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    applyStimulus(1, 25'd320, 0, 25'd0, 16'h0);
    waitValid("t3_later", lat);
    checkOutput("t3_later_readdata", 32'(readdata), 32'h5555);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    // Simultaneous read and write: write wins, busy after the acceptance edge and the
    // seven edges that follow it (nine edges occupied in total).
    pulseReset();
    checkOutput("t4_drop_cleared", 32'(err_drop), 32'h0);
    applyStimulus(1, 25'd32, 1, 25'd32, 16'hBEEF);
    checkOutput("t4_err_drop", 32'(err_drop), 32'h1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t4_busy_cycles", n, 8);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    applyStimulus(1, 25'd32, 0, 25'd0, 16'h0);
    waitValid("t4", lat);
    checkOutput("t4_readdata", 32'(readdata), 32'hBEEF);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    // Misaligned and out-of-range reads.
    pulseReset();
    preload(10'd1, 16'h0101);
    applyStimulus(1, 25'd24, 0, 25'd0, 16'h0);
    waitValid("t5_align", lat);
    checkOutput("t5_align_readdata", 32'(readdata), 32'h0101);
    checkOutput("t5_err_align", 32'(err_align), 32'h1);
    checkOutput("t5_err_range_clear", 32'(err_range), 32'h0);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    applyStimulus(1, 25'(16 * DEPTH), 0, 25'd0, 16'h0);
    waitValid("t5_range", lat);
    checkOutput("t5_range_rd_valid", 32'(rd_valid), 32'h1);
    checkOutput("t5_range_readdata", 32'(readdata), 32'h0);
    checkOutput("t5_err_range", 32'(err_range), 32'h1);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    // Reset one edge into a read; strobe held high across reset re-requests once.
    pulseReset();
    preload(10'd7, 16'h7777);
    applyStimulus(1, 25'd80, 0, 25'd0, 16'h0);
    waitValid("t6_pre", lat);
    checkOutput("t6_pre_readdata", 32'(readdata), 32'h00AA);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);
    applyStimulus(1, 25'd112, 0, 25'd0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy_in_reset", 32'(busy), 32'h0);
    checkOutput("t6_readdata_in_reset", 32'(readdata), 32'h0);
    checkOutput("t6_rd_valid_in_reset", 32'(rd_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_rerequest_busy", 32'(busy), 32'h1);
    waitValid("t6", lat);
    checkOutput("t6_latency", lat, 3);
    checkOutput("t6_readdata", 32'(readdata), 32'h7777);
    countValid(8, n);
    checkOutput("t6_single_request", n, 0);
    applyStimulus(0, 25'd0, 0, 25'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
